// File: rtl/wb_user_decoder_pkg.sv
// Shared definitions for the user-region Wishbone decoder: FSM state encoding,
// error read-data default and error-counter width with its saturating increment.
package wb_user_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic [31:0] WB_ERR_DATA = 32'hDEADBEEF;
   localparam int          ERR_CNT_W   = 8;

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/wb_user_decoder_timeout_ctr.sv
// Bus-timeout watchdog: cleared outside BUSY, counts BUSY cycles and flags the
// TIMEOUT-th cycle so the FSM can force an ack on that edge.
module wb_timeout_ctr #(
   parameter int TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int                CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The counter parks at LAST, so expiry holds until the FSM leaves BUSY.
   assign expired_o = en_i && (cnt_q == LAST);

   always_comb begin
      // NOTE: assigning a default first means every path drives cnt_d, so no latch is inferred.
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_user_decoder.sv
// Wishbone classic decoder for the user window: registers the request to one of
// NSLV slaves, registers the response, and forces an ack when a slave stays silent.
module wb_user_decoder
   import wb_user_decoder_pkg::*;
#(
   parameter int          NSLV     = 4,
   parameter int          SEL_LSB  = 16,
   parameter int          SEL_W    = 2,
   parameter int          TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = WB_ERR_DATA
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  wbs_cyc_i,
   input  logic                  wbs_stb_i,
   input  logic                  wbs_we_i,
   input  logic [3:0]            wbs_sel_i,
   input  logic [31:0]           wbs_adr_i,
   input  logic [31:0]           wbs_dat_i,
   output logic                  wbs_ack_o,
   output logic [31:0]           wbs_dat_o,
   output logic [NSLV-1:0]       s_cyc_o,
   output logic [NSLV-1:0]       s_stb_o,
   output logic                  s_we_o,
   output logic [3:0]            s_sel_o,
   output logic [31:0]           s_adr_o,
   output logic [31:0]           s_dat_o,
   input  logic [NSLV-1:0]       s_ack_i,
   input  logic [NSLV*32-1:0]    s_dat_i,
   output logic                  timeout_o,
   output logic [ERR_CNT_W-1:0]  err_cnt_o
);

   state_e                 state_q;
   logic                   ack_q;
   logic [31:0]            rdata_q;
   logic [NSLV-1:0]        s_cyc_q;
   logic                   s_we_q;
   logic [3:0]             s_sel_q;
   logic [31:0]            s_adr_q;
   logic [31:0]            s_dat_q;
   logic                   timeout_q;
   logic [ERR_CNT_W-1:0]   err_cnt_q;

   logic [SEL_W-1:0]       req_idx;
   logic [NSLV-1:0]        req_onehot;
   logic                   req_mapped;
   logic                   slv_ack;
   logic [31:0]            slv_rdata;
   logic                   expired;

   assign req_idx = wbs_adr_i[SEL_LSB +: SEL_W];

   always_comb begin
      req_onehot = '0;
      for (int k = 0; k < NSLV; k++) begin
         if (req_idx == SEL_W'(k)) begin
            req_onehot[k] = 1'b1;
         end
      end
      req_mapped = |req_onehot;
   end

   // s_cyc_q doubles as the latched one-hot slave index while BUSY.
   always_comb begin
      slv_ack   = |(s_ack_i & s_cyc_q);
      slv_rdata = '0;
      for (int k = 0; k < NSLV; k++) begin
         if (s_cyc_q[k]) begin
            slv_rdata = s_dat_i[32*k +: 32];
         end
      end
   end

   wb_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_ctr (
      .clk_i     (wb_clk_i),
      .rst_i     (wb_rst_i),
      .clr_i     (state_q != ST_BUSY),
      .en_i      (state_q == ST_BUSY),
      .expired_o (expired)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= ST_IDLE;
         ack_q     <= 1'b0;
         rdata_q   <= '0;
         s_cyc_q   <= '0;
         s_we_q    <= 1'b0;
         s_sel_q   <= '0;
         s_adr_q   <= '0;
         s_dat_q   <= '0;
         timeout_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         ack_q     <= 1'b0;
         rdata_q   <= '0;
         timeout_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (wbs_cyc_i && wbs_stb_i) begin
                  s_we_q  <= wbs_we_i;
                  s_sel_q <= wbs_sel_i;
                  s_adr_q <= wbs_adr_i;
                  s_dat_q <= wbs_dat_i;
                  if (req_mapped) begin
                     s_cyc_q <= req_onehot;
                     state_q <= ST_BUSY;
                  end else begin
                     ack_q     <= 1'b1;
                     rdata_q   <= ERR_DATA;
                     err_cnt_q <= sat_inc(err_cnt_q);
                     state_q   <= ST_RESP;
                  end
               end
            end
            ST_BUSY: begin
               // Abort outranks the slave ack; an ack on the expiry cycle outranks the timeout.
               if (!wbs_cyc_i) begin
                  s_cyc_q <= '0;
                  state_q <= ST_IDLE;
               end else if (slv_ack) begin
                  s_cyc_q <= '0;
                  ack_q   <= 1'b1;
                  rdata_q <= slv_rdata;
                  state_q <= ST_RESP;
               end else if (expired) begin
                  s_cyc_q   <= '0;
                  ack_q     <= 1'b1;
                  rdata_q   <= ERR_DATA;
                  timeout_q <= 1'b1;
                  err_cnt_q <= sat_inc(err_cnt_q);
                  state_q   <= ST_RESP;
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               s_cyc_q <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = rdata_q;
   assign s_cyc_o   = s_cyc_q;
   assign s_stb_o   = s_cyc_q;
   assign s_we_o    = s_we_q;
   assign s_sel_o   = s_sel_q;
   assign s_adr_o   = s_adr_q;
   assign s_dat_o   = s_dat_q;
   assign timeout_o = timeout_q;
   assign err_cnt_o = err_cnt_q;

endmodule
